// File: rtl/basys3_7seg_decoder.sv
// Basys3 seven-segment bus snooper: recovers the four hex digits from a scanned display.
// Optional stale-digit timeout enabled by defining BASYS3_7SEG_DECODER_STALE_TIMEOUT_EN.
module basys3_7seg_decoder #(
    parameter int unsigned STALE_CYCLES = 16
) (
    input  logic        clk_1k_i,
    input  logic        rst_ni,
    input  logic [3:0]  anode_i,
    input  logic [6:0]  segments_i,
    input  logic        err_clr_i,
    output logic [3:0]  digit_en_o,
    output logic [15:0] digit_o,
    output logic        frame_o,
    output logic        glyph_err_o,
    output logic        multi_err_o
);

    if (STALE_CYCLES < 2 || STALE_CYCLES > 255) begin : g_bad_cfg
        $error("STALE_CYCLES must lie in 2..255");
    end

    logic [3:0]  anode_q;
    logic [6:0]  seg_q;
    logic [3:0]  digit_en_q, digit_en_d;
    logic [15:0] digit_q, digit_d;
    logic [3:0]  seen_q, seen_d;
    logic        frame_q, frame_d;
    logic        glyph_err_q, glyph_err_d;
    logic        multi_err_q, multi_err_d;

    logic        strobe;
    logic [1:0]  idx;
    logic [2:0]  nlow;
    logic        multi;
    logic        blank;
    logic        glyph_ok;
    logic [3:0]  glyph_val;
    logic        glyph_set;
    logic [3:0]  mask_n;
    logic [3:0]  stale_hit;

    // Stage 1: plain capture of the display bus.
    always_ff @(posedge clk_1k_i or negedge rst_ni) begin
        if (!rst_ni) begin
            anode_q <= 4'hF;
            seg_q   <= 7'h7F;
        end else begin
            anode_q <= anode_i;
            seg_q   <= segments_i;
        end
    end

    always_comb begin
        strobe = 1'b0;
        idx    = 2'd0;
        case (anode_q)
            4'b1110: begin strobe = 1'b1; idx = 2'd0; end
            4'b1101: begin strobe = 1'b1; idx = 2'd1; end
            4'b1011: begin strobe = 1'b1; idx = 2'd2; end
            4'b0111: begin strobe = 1'b1; idx = 2'd3; end
            default: begin strobe = 1'b0; idx = 2'd0; end
        endcase
    end

    always_comb begin
        nlow = 3'd0;
        for (int i = 0; i < 4; i++) begin
            nlow = nlow + {2'b00, ~anode_q[i]};
        end
        multi = (nlow >= 3'd2);
    end

    // Active-low glyph table, pattern is {g,f,e,d,c,b,a}.
    always_comb begin
        glyph_ok  = 1'b1;
        glyph_val = 4'h0;
        case (seg_q)
            7'b1000000: glyph_val = 4'h0;
            7'b1111001: glyph_val = 4'h1;
            7'b0100100: glyph_val = 4'h2;
            7'b0110000: glyph_val = 4'h3;
            7'b0011001: glyph_val = 4'h4;
            7'b0010010: glyph_val = 4'h5;
            7'b0000010: glyph_val = 4'h6;
            7'b1111000: glyph_val = 4'h7;
            7'b0000000: glyph_val = 4'h8;
            7'b0010000: glyph_val = 4'h9;
            7'b0001000: glyph_val = 4'hA;
            7'b0000011: glyph_val = 4'hB;
            7'b1000110: glyph_val = 4'hC;
            7'b0100001: glyph_val = 4'hD;
            7'b0000110: glyph_val = 4'hE;
            7'b0001110: glyph_val = 4'hF;
            default:    glyph_ok  = 1'b0;
        endcase
        blank = (seg_q == 7'h7F);
    end

`ifdef BASYS3_7SEG_DECODER_STALE_TIMEOUT_EN
    localparam logic [7:0] STALE_LIM = 8'(STALE_CYCLES);

    logic [7:0] stale_q [4];
    logic [7:0] stale_d [4];

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            stale_d[k]   = 8'd0;
            stale_hit[k] = 1'b0;
            if (!(strobe && idx == 2'(k))) begin
                stale_d[k] = (stale_q[k] == 8'hFF) ? 8'hFF
                                                   : stale_q[k] + 8'd1;
                // Fire only on the edge the limit is first reached.
                stale_hit[k] = (stale_d[k] == STALE_LIM)
                             && (stale_q[k] != STALE_LIM);
            end
        end
    end

    always_ff @(posedge clk_1k_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < 4; k++) stale_q[k] <= 8'd0;
        end else begin
            for (int k = 0; k < 4; k++) stale_q[k] <= stale_d[k];
        end
    end
`else
    assign stale_hit = 4'b0000;
`endif

    always_comb begin
        digit_en_d = digit_en_q & ~stale_hit;
        digit_d    = digit_q;
        glyph_set  = 1'b0;
        if (strobe) begin
            if (blank) begin
                digit_en_d[idx] = 1'b0;
            end else if (glyph_ok) begin
                digit_en_d[idx]           = 1'b1;
                digit_d[{idx, 2'b00} +: 4] = glyph_val;
            end else begin
                digit_en_d[idx] = 1'b0;
                glyph_set       = 1'b1;
            end
        end
    end

    // Frame tracking: the completing strobe closes the current frame.
    always_comb begin
        mask_n = seen_q;
        if (strobe) mask_n[idx] = 1'b1;
        frame_d = (mask_n == 4'hF);
        seen_d  = frame_d ? 4'h0 : mask_n;
    end

    always_comb begin
        glyph_err_d = glyph_set | (glyph_err_q & ~err_clr_i);
        multi_err_d = multi     | (multi_err_q & ~err_clr_i);
    end

    always_ff @(posedge clk_1k_i or negedge rst_ni) begin
        if (!rst_ni) begin
            digit_en_q  <= 4'h0;
            digit_q     <= 16'h0000;
            seen_q      <= 4'h0;
            frame_q     <= 1'b0;
            glyph_err_q <= 1'b0;
            multi_err_q <= 1'b0;
        end else begin
            digit_en_q  <= digit_en_d;
            digit_q     <= digit_d;
            seen_q      <= seen_d;
            frame_q     <= frame_d;
            glyph_err_q <= glyph_err_d;
            multi_err_q <= multi_err_d;
        end
    end

    assign digit_en_o  = digit_en_q;
    assign digit_o     = digit_q;
    assign frame_o     = frame_q;
    assign glyph_err_o = glyph_err_q;
    assign multi_err_o = multi_err_q;

endmodule

// File: tb/tb_basys3_7seg_decoder.sv
// Directed bench for basys3_7seg_decoder with hand-computed expectations.
module tb_basys3_7seg_decoder;

    logic        clk;
    logic        rst_n;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        err_clr;
    logic [3:0]  digit_en;
    logic [15:0] digit;
    logic        frame;
    logic        glyph_err;
    logic        multi_err;

    int n_chk = 0;
    int n_err = 0;

    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G3 = 7'b0110000;
    localparam logic [6:0] G5 = 7'b0010010;
    localparam logic [6:0] G7 = 7'b1111000;
    localparam logic [6:0] G8 = 7'b0000000;
    localparam logic [6:0] GA = 7'b0001000;
    localparam logic [6:0] GF = 7'b0001110;
    localparam logic [6:0] BLK = 7'b1111111;
    localparam logic [6:0] BAD = 7'b1010101;

    basys3_7seg_decoder #(.STALE_CYCLES(16)) dut (
        .clk_1k_i    (clk),
        .rst_ni      (rst_n),
        .anode_i     (anode),
        .segments_i  (seg),
        .err_clr_i   (err_clr),
        .digit_en_o  (digit_en),
        .digit_o     (digit),
        .frame_o     (frame),
        .glyph_err_o (glyph_err),
        .multi_err_o (multi_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one scan slot, then idle; returns at the negedge after outputs update.
    task automatic drive(input logic [3:0] an, input logic [6:0] sg);
        @(negedge clk);
        anode = an;
        seg   = sg;
        @(negedge clk);
        anode = 4'hF;
        seg   = BLK;
        @(negedge clk);
    endtask

    task automatic strobe(input int k, input logic [6:0] sg);
        logic [3:0] an;
        an = 4'hF;
        an[k] = 1'b0;
        drive(an, sg);
    endtask

    initial begin
        rst_n   = 1'b0;
        anode   = 4'hF;
        seg     = BLK;
        err_clr = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_en", 32'(digit_en), 32'h0);
        check("rst_digit", 32'(digit), 32'h0);
        check("rst_frame", 32'(frame), 32'h0);
        check("rst_gerr", 32'(glyph_err), 32'h0);
        check("rst_merr", 32'(multi_err), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        strobe(0, G3);
        check("cyc_f0", 32'(frame), 32'h0);
        strobe(1, GA);
        check("cyc_f1", 32'(frame), 32'h0);
        strobe(2, G0);
        check("cyc_f2", 32'(frame), 32'h0);
        strobe(3, GF);
        check("cyc_frame", 32'(frame), 32'h1);
        check("cyc_digit", 32'(digit), 32'hF0A3);
        check("cyc_en", 32'(digit_en), 32'hF);
        @(negedge clk);
        check("cyc_once", 32'(frame), 32'h0);

        strobe(1, G5);
        check("d1_val", 32'(digit[7:4]), 32'h5);
        check("d1_en", 32'(digit_en[1]), 32'h1);
        strobe(1, BLK);
        check("blank_en", 32'(digit_en[1]), 32'h0);
        check("blank_val", 32'(digit[7:4]), 32'h5);
        check("blank_gerr", 32'(glyph_err), 32'h0);
        check("blank_merr", 32'(multi_err), 32'h0);

        strobe(0, BAD);
        check("bad_gerr", 32'(glyph_err), 32'h1);
        check("bad_en0", 32'(digit_en[0]), 32'h0);
        check("bad_val0", 32'(digit[3:0]), 32'h3);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("clr_gerr", 32'(glyph_err), 32'h0);

        drive(4'b1100, G8);
        check("multi_err", 32'(multi_err), 32'h1);
        check("multi_dig", 32'(digit[7:0]), 32'h53);
        check("multi_en", 32'(digit_en[1:0]), 32'h0);
        check("multi_frame", 32'(frame), 32'h0);
        check("multi_gerr", 32'(glyph_err), 32'h0);
        strobe(2, G7);
        check("mask_f2", 32'(frame), 32'h0);
        strobe(3, GF);
        check("mask_frame", 32'(frame), 32'h1);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("clr_merr", 32'(multi_err), 32'h0);

        strobe(2, G7);
        check("st_val", 32'(digit[11:8]), 32'h7);
        check("st_en0", 32'(digit_en[2]), 32'h1);
        repeat (15) @(negedge clk);
        check("st_en15", 32'(digit_en[2]), 32'h1);
        @(negedge clk);
`ifdef BASYS3_7SEG_DECODER_STALE_TIMEOUT_EN
        check("st_en16", 32'(digit_en[2]), 32'h0);
`else
        check("st_en16", 32'(digit_en[2]), 32'h1);
`endif
        check("st_hold", 32'(digit[11:8]), 32'h7);

        strobe(0, G0);
        strobe(1, G5);
        #2 rst_n = 1'b0;
        #1;
        check("ar_en", 32'(digit_en), 32'h0);
        check("ar_digit", 32'(digit), 32'h0);
        check("ar_frame", 32'(frame), 32'h0);
        check("ar_err", 32'({glyph_err, multi_err}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        strobe(2, G7);
        check("ar_f2", 32'(frame), 32'h0);
        strobe(3, G3);
        check("ar_f3", 32'(frame), 32'h0);
        strobe(0, G8);
        check("ar_f0", 32'(frame), 32'h0);
        strobe(1, GA);
        check("ar_frame1", 32'(frame), 32'h1);
        check("ar_dig", 32'(digit), 32'h37A8);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
